// File: rtl/mem_line_adapter.sv
// ============================================================================
// mem_line_adapter: arbitrates the icache/dcache line requests onto a 4-beat
// burst memory.  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_line_adapter #(
  parameter int LINE_W  = 256,
  parameter int BEAT_W  = 64,
  parameter int N_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [31:0]       d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [31:0]       bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int BIDX_W  = $clog2(LINE_W);
  localparam int BSHIFT  = $clog2(BEAT_W);
  localparam logic [31:0] ALIGN_MASK = ~(32'(LINE_W / 8) - 32'd1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  typedef enum logic [1:0] {
    adapter_idle = 2'd0,
    read         = 2'd1,
    write        = 2'd2,
    response     = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              last_d;   // 1 = dcache received the most recent grant
  logic              own_d;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] rbuf, wbuf, i_rdata_q, d_rdata_q, rbuf_next;
  logic [BIDX_W-1:0] base;
  logic              i_req, d_req, gnt, gnt_d, gnt_wr, hit, is_last;
  logic [31:0]       sel_addr, gnt_addr;

  assign i_req    = i_read;
  assign d_req    = d_read | d_write;
  assign base     = BIDX_W'(cnt) << BSHIFT;
  assign is_last  = (cnt == LAST_BEAT);
  assign hit      = bmem_rvalid && (bmem_raddr == addr_q);
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

  // Round-robin: on a tie the port that did not win last time is chosen.
  assign gnt      = bmem_ready && (i_req || d_req);
  assign gnt_d    = d_req && (!i_req || !last_d);
  assign gnt_wr   = gnt_d && d_write;
  assign sel_addr = gnt_d ? d_addr : i_addr;
  assign gnt_addr = sel_addr & ALIGN_MASK;

  always_comb begin
    rbuf_next             = rbuf;
    rbuf_next[base +: BEAT_W] = bmem_rdata;
  end

  always_comb begin
    state_next = state;
    bmem_addr  = '0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      adapter_idle: begin
        if (gnt) begin
          bmem_addr = gnt_addr;
          if (gnt_wr) begin
            bmem_write = 1'b1;
            bmem_wdata = d_wdata[BEAT_W-1:0];
            state_next = write;
          end else begin
            bmem_read  = 1'b1;
            state_next = read;
          end
        end
      end
      read: begin
        bmem_addr = addr_q;
        if (hit && is_last) state_next = response;
      end
      write: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = wbuf[base +: BEAT_W];
        if (bmem_ready && is_last) state_next = response;
      end
      response: begin
        i_resp     = !own_d;
        d_resp     = own_d;
        state_next = adapter_idle;
      end
      default: state_next = adapter_idle;
    endcase
    if (rst) begin
      bmem_addr  = '0;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_wdata = '0;
      i_resp     = 1'b0;
      d_resp     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= adapter_idle;
      cnt       <= '0;
      last_d    <= 1'b0;
      own_d     <= 1'b0;
      addr_q    <= '0;
      rbuf      <= '0;
      wbuf      <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        adapter_idle: begin
          if (gnt) begin
            own_d  <= gnt_d;
            last_d <= gnt_d;
            addr_q <= gnt_addr;
            wbuf   <= d_wdata;
            // Beat 0 of a write leaves in the grant cycle itself.
            cnt    <= gnt_wr ? CNT_W'(1) : '0;
          end
        end
        read: begin
          if (hit) begin
            rbuf <= rbuf_next;
            cnt  <= cnt + CNT_W'(1);
            if (is_last) begin
              if (own_d) d_rdata_q <= rbuf_next;
              else       i_rdata_q <= rbuf_next;
            end
          end
        end
        write: begin
          if (bmem_ready) cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_line_adapter.sv
// Scoreboard bench for mem_line_adapter: expected lines/beats are queued when
// stimulus is driven and popped when the adapter answers.
`timescale 1ns/1ps
`default_nettype none

module tb_mem_line_adapter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  i_addr = '0;
  logic         i_read = 1'b0;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic [31:0]  d_addr = '0;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [255:0] d_wdata = '0;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready = 1'b1;
  logic [31:0]  bmem_raddr = '0;
  logic [63:0]  bmem_rdata = '0;
  logic         bmem_rvalid = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [255:0] rq[$];
  logic [63:0]  wq[$];
  logic [255:0] last_i_line = '0;

  mem_line_adapter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input logic [3:0] k);
    return {16{k}};
  endfunction

  task automatic send_beat(input logic [31:0] a, input logic [63:0] d);
    bmem_rvalid = 1'b1;
    bmem_raddr  = a;
    bmem_rdata  = d;
    @(negedge clk);
    bmem_rvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; i_read = 1'b1; d_read = 1'b0; d_write = 1'b0;
    bmem_ready = 1'b1; bmem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bmem_read !== 1'b0 || bmem_write !== 1'b0 || bmem_addr !== 32'h0 ||
        i_resp !== 1'b0 || d_resp !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%b wr=%b addr=%h iresp=%b dresp=%b, required all 0",
               bmem_read, bmem_write, bmem_addr, i_resp, d_resp);
    end
    checks++;
    if (i_rdata !== 256'h0 || d_rdata !== 256'h0) begin
      errors++;
      $display("FAIL reset_rdata: i_rdata=%h d_rdata=%h, required 0", i_rdata, d_rdata);
    end
    i_read = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_icache_read;
    logic [255:0] exp, got;
    @(negedge clk);
    i_addr = 32'h1234_5678; i_read = 1'b1; bmem_ready = 1'b1;
    #1;
    checks++;
    if (bmem_read !== 1'b1 || bmem_write !== 1'b0 || bmem_addr !== 32'h1234_5660) begin
      errors++;
      $display("FAIL icache_grant: rd=%b wr=%b addr=%h, required 1 0 12345660",
               bmem_read, bmem_write, bmem_addr);
    end
    exp = {pat(4'd3), pat(4'd2), pat(4'd1), pat(4'd0)};
    rq.push_back(exp);
    @(negedge clk); #1;
    checks++;
    if (bmem_read !== 1'b0) begin
      errors++;
      $display("FAIL icache_read_one_cycle: bmem_read=%b, required 0", bmem_read);
    end
    for (int k = 0; k < 4; k++) send_beat(32'h1234_5660, pat(4'(k)));
    #1;
    got = rq.pop_front();
    checks++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== got) begin
      errors++;
      $display("FAIL icache_resp: iresp=%b dresp=%b i_rdata=%h, required 1 0 %h",
               i_resp, d_resp, i_rdata, got);
    end
    last_i_line = got;
    i_read = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (i_resp !== 1'b0) begin
      errors++;
      $display("FAIL icache_resp_one_cycle: i_resp=%b, required 0", i_resp);
    end
  endtask

  task automatic run_write(input string name, input logic [31:0] addr,
                           input logic [255:0] line, input bit stall, input int exp_t);
    int t;
    for (int k = 0; k < 4; k++) wq.push_back(line[k*64 +: 64]);
    @(negedge clk);
    d_addr = addr; d_wdata = line; d_write = 1'b1; bmem_ready = 1'b1;
    #1;
    checks++;
    if (bmem_write !== 1'b1 || bmem_read !== 1'b0 || bmem_addr !== addr ||
        bmem_wdata !== wq[0]) begin
      errors++;
      $display("FAIL %s_grant: wr=%b rd=%b addr=%h wdata=%h, required 1 0 %h %h",
               name, bmem_write, bmem_read, bmem_addr, bmem_wdata, addr, wq[0]);
    end
    void'(wq.pop_front());
    t = 0;
    while (wq.size() > 0 && t < 20) begin
      @(negedge clk);
      t++;
      d_wdata = ~line;
      bmem_ready = !(stall && (t == 2 || t == 3));
      #1;
      checks++;
      if (bmem_write !== 1'b1 || bmem_read !== 1'b0 || bmem_addr !== addr ||
          bmem_wdata !== wq[0] || d_resp !== 1'b0) begin
        errors++;
        $display("FAIL %s_beat t=%0d: wr=%b rd=%b addr=%h wdata=%h dresp=%b, required 1 0 %h %h 0",
                 name, t, bmem_write, bmem_read, bmem_addr, bmem_wdata, d_resp, addr, wq[0]);
      end
      if (bmem_ready) void'(wq.pop_front());
    end
    wq.delete();
    @(negedge clk);
    t++;
    bmem_ready = 1'b1;
    #1;
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || bmem_write !== 1'b0) begin
      errors++;
      $display("FAIL %s_resp at T+%0d (required T+%0d): dresp=%b iresp=%b wr=%b, required 1 0 0",
               name, t, exp_t, d_resp, i_resp, bmem_write);
    end
    d_write = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (d_resp !== 1'b0) begin
      errors++;
      $display("FAIL %s_resp_one_cycle: d_resp=%b, required 0", name, d_resp);
    end
  endtask

  task automatic test_dcache_write;
    logic [255:0] line;
    for (int k = 0; k < 4; k++) line[k*64 +: 64] = 64'hA5A5_A5A5_A5A5_A500 + 64'(k);
    run_write("dwrite", 32'h8000_0040, line, 1'b0, 4);
  endtask

  task automatic test_write_backpressure;
    logic [255:0] line;
    for (int k = 0; k < 4; k++) line[k*64 +: 64] = 64'h5A5A_5A5A_5A5A_5A00 + 64'(k);
    run_write("bp_write", 32'h8000_0080, line, 1'b1, 6);
  endtask

  task automatic test_arbitration;
    logic [31:0]  ia, da, wa;
    logic [255:0] exp, got;
    bit           win_d;
    rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      ia = 32'h0000_3000 + 32'(n) * 32'h100;
      da = 32'h0000_7000 + 32'(n) * 32'h100;
      i_addr = ia; d_addr = da; i_read = 1'b1; d_read = 1'b1;
      #1;
      win_d = (n % 2 == 0);
      wa = win_d ? da : ia;
      checks++;
      if (bmem_read !== 1'b1 || bmem_addr !== wa) begin
        errors++;
        $display("FAIL arb_grant n=%0d: rd=%b addr=%h, required 1 %h", n, bmem_read, bmem_addr, wa);
      end
      for (int k = 0; k < 4; k++) exp[k*64 +: 64] = pat(4'(n * 4 + k));
      rq.push_back(exp);
      @(negedge clk);
      for (int k = 0; k < 4; k++) send_beat(wa, exp[k*64 +: 64]);
      #1;
      got = rq.pop_front();
      checks++;
      if (win_d) begin
        if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== got) begin
          errors++;
          $display("FAIL arb_resp n=%0d: dresp=%b iresp=%b d_rdata=%h, required 1 0 %h",
                   n, d_resp, i_resp, d_rdata, got);
        end
      end else begin
        if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== got) begin
          errors++;
          $display("FAIL arb_resp n=%0d: iresp=%b dresp=%b i_rdata=%h, required 1 0 %h",
                   n, i_resp, d_resp, i_rdata, got);
        end
        last_i_line = got;
      end
      i_read = 1'b0; d_read = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_stray_beats;
    logic [31:0]  a;
    logic [255:0] exp, got;
    a = 32'h0000_2000;
    @(negedge clk);
    d_addr = 32'h0000_2010; d_read = 1'b1;
    #1;
    checks++;
    if (bmem_read !== 1'b1 || bmem_addr !== a) begin
      errors++;
      $display("FAIL stray_grant: rd=%b addr=%h, required 1 %h", bmem_read, bmem_addr, a);
    end
    for (int k = 0; k < 4; k++) exp[k*64 +: 64] = 64'hC0FF_EE00_0000_0000 + 64'(k);
    rq.push_back(exp);
    @(negedge clk);
    send_beat(32'hDEAD_BEE0, 64'hBAD0_BAD0_BAD0_BAD0);
    send_beat(a, exp[63:0]);
    send_beat(32'hDEAD_BEE0, 64'hBAD1_BAD1_BAD1_BAD1);
    send_beat(a, exp[127:64]);
    bmem_raddr = a; bmem_rdata = 64'hBAD2_BAD2_BAD2_BAD2;
    @(negedge clk);
    send_beat(a, exp[191:128]);
    send_beat(32'hDEAD_BEE0, 64'hBAD3_BAD3_BAD3_BAD3);
    #1;
    checks++;
    if (d_resp !== 1'b0) begin
      errors++;
      $display("FAIL stray_early_resp: d_resp=%b, required 0", d_resp);
    end
    send_beat(a, exp[255:192]);
    #1;
    got = rq.pop_front();
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== got) begin
      errors++;
      $display("FAIL stray_resp: dresp=%b iresp=%b d_rdata=%h, required 1 0 %h",
               d_resp, i_resp, d_rdata, got);
    end
    checks++;
    if (i_rdata !== last_i_line) begin
      errors++;
      $display("FAIL irdata_hold: i_rdata=%h, required %h", i_rdata, last_i_line);
    end
    d_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read;
    logic [255:0] exp, got;
    bit           seen;
    @(negedge clk);
    i_addr = 32'h0000_4000; i_read = 1'b1;
    #1;
    checks++;
    if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_4000) begin
      errors++;
      $display("FAIL rstmid_grant: rd=%b addr=%h, required 1 00004000", bmem_read, bmem_addr);
    end
    @(negedge clk);
    send_beat(32'h0000_4000, pat(4'hE));
    send_beat(32'h0000_4000, pat(4'hD));
    rst = 1'b1; i_read = 1'b0;
    send_beat(32'h0000_4000, pat(4'hC));
    rst = 1'b0;
    send_beat(32'h0000_4000, pat(4'hB));
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (i_resp !== 1'b0 || d_resp !== 1'b0 || bmem_read !== 1'b0 || bmem_write !== 1'b0)
        seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rstmid_quiet: activity after reset seen=%b, required 0", seen);
    end
    checks++;
    if (i_rdata !== 256'h0) begin
      errors++;
      $display("FAIL rstmid_rdata: i_rdata=%h, required 0", i_rdata);
    end
    i_addr = 32'h0000_5000; i_read = 1'b1;
    #1;
    checks++;
    if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_5000) begin
      errors++;
      $display("FAIL rstmid_regrant: rd=%b addr=%h, required 1 00005000", bmem_read, bmem_addr);
    end
    exp = {pat(4'h7), pat(4'h6), pat(4'h5), pat(4'h4)};
    rq.push_back(exp);
    @(negedge clk);
    for (int k = 0; k < 4; k++) send_beat(32'h0000_5000, exp[k*64 +: 64]);
    #1;
    got = rq.pop_front();
    checks++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== got) begin
      errors++;
      $display("FAIL rstmid_resp: iresp=%b dresp=%b i_rdata=%h, required 1 0 %h",
               i_resp, d_resp, i_rdata, got);
    end
    i_read = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_icache_read;
    test_dcache_write;
    test_write_backpressure;
    test_arbitration;
    test_stray_beats;
    test_reset_mid_read;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
